// File: rtl/monitor_pio_pkg.sv
// rtl/monitor_pio_pkg.sv - register map and edge-type encodings for the PIO edge monitor
package monitor_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic edge_bit(input logic prev, input logic cur, input int etype);
    logic hit;
    case (etype)
      EDGE_RISE: hit = ~prev & cur;
      EDGE_FALL: hit = prev & ~cur;
      default:   hit = prev ^ cur;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/monitor_pio_sync.sv
// rtl/monitor_pio_sync.sv - per-bit flop chain bringing asynchronous inputs into the clk domain
module monitor_pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/monitor_pio_in_edge.sv
// rtl/monitor_pio_in_edge.sv - Avalon-MM input port with edge capture, irq mask and warm-up gating
module monitor_pio_in_edge
  import monitor_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int WU_W = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic [WU_W-1:0]  wu_q, wu_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             armed;
  logic             unused_wdata;

  monitor_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (in_port),
    .q_o   (data)
  );

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // The sync chain and prev start at 0, so a static high input looks like an edge until both have filled.
  assign armed = (wu_q == '0);
  assign wu_d  = armed ? wu_q : wu_q - WU_W'(1);

  always_comb begin
    edge_det = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_det[i] = armed & edge_bit(prev_q[i], data[i], EDGE_TYPE);
    end
  end

  always_comb begin
    clr_mask  = '0;
    irqmask_d = irqmask_q;
    if (wr_en && (address == ADDR_EDGECAP)) clr_mask = writedata[WIDTH-1:0];
    if (wr_en && (address == ADDR_IRQMASK)) irqmask_d = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
    irq_d     = |(edgecap_q & irqmask_q);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = data;
      ADDR_RSVD:    readdata_d = '0;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      wu_q       <= WU_W'(SYNC_STAGES + 1);
    end else begin
      prev_q     <= data;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      wu_q       <= wu_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_monitor_pio_in_edge.sv
// tb/tb_monitor_pio_in_edge.sv - directed checks on rising, falling, any-edge and 32-bit instances
module tb_monitor_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  cs;
  logic [7:0]  in_r, in_a, in_f;
  logic [31:0] in_w;
  logic [31:0] rd_r, rd_a, rd_f, rd_w;
  logic        irq_r, irq_a, irq_f, irq_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  monitor_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]), .write_n(write_n),
    .writedata(writedata), .in_port(in_r), .readdata(rd_r), .irq(irq_r));

  monitor_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

  monitor_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(2)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]), .write_n(write_n),
    .writedata(writedata), .in_port(in_f), .readdata(rd_f), .irq(irq_f));

  monitor_pio_in_edge #(.WIDTH(32), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_w32 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[3]), .write_n(write_n),
    .writedata(writedata), .in_port(in_w), .readdata(rd_w), .irq(irq_w));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int idx, input logic [1:0] a, input logic [31:0] d);
    cs[idx]   = 1'b1;
    write_n   = 1'b0;
    address   = a;
    writedata = d;
    tick(1);
    cs        = '0;
    write_n   = 1'b1;
    writedata = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; write_n = 1'b1; writedata = '0; cs = '0;
    in_r = 8'hA5; in_a = 8'h00; in_f = 8'hFF; in_w = 32'h1234_5678;
    tick(2);
    chk("reset_rd_r", rd_r, 32'h0);
    chk("reset_irq_r", {31'b0, irq_r}, 32'h0);
    chk("reset_rd_w", rd_w, 32'h0);

    reset = 1'b0;
    tick(5);
    address = 2'd0; tick(1);
    chk("warm_data_r", rd_r, 32'h0000_00A5);
    chk("warm_data_f", rd_f, 32'h0000_00FF);
    chk("warm_data_w", rd_w, 32'h1234_5678);
    address = 2'd3; tick(1);
    chk("warm_ecap_r", rd_r, 32'h0);
    chk("warm_ecap_w", rd_w, 32'h0);
    chk("warm_irq_r", {31'b0, irq_r}, 32'h0);

    wr(0, 2'd2, 32'h1);
    in_r = 8'hA4; address = 2'd3; tick(4);
    chk("rise_ignores_fall", rd_r, 32'h0);
    in_r = 8'hA5; tick(3);
    chk("lat_ecap_before", rd_r, 32'h0);
    chk("lat_irq_before", {31'b0, irq_r}, 32'h0);
    tick(1);
    chk("lat_ecap_set", rd_r, 32'h1);
    chk("lat_irq_set", {31'b0, irq_r}, 32'h1);
    tick(3);
    chk("ecap_held", rd_r, 32'h1);

    wr(0, 2'd3, 32'h1); tick(1);
    chk("clr_ecap", rd_r, 32'h0);
    chk("clr_irq", {31'b0, irq_r}, 32'h0);
    tick(3);
    chk("no_recapture", rd_r, 32'h0);

    in_r = 8'hA4; tick(4);
    in_r = 8'hA5; tick(4);
    chk("second_edge", rd_r, 32'h1);
    in_r = 8'hA4; tick(4);
    in_r = 8'hA5; tick(2);
    wr(0, 2'd3, 32'h1); tick(1);
    chk("edge_beats_clear", rd_r, 32'h1);
    chk("edge_beats_clear_irq", {31'b0, irq_r}, 32'h1);
    wr(0, 2'd3, 32'h1); tick(1);
    chk("clear_after_race", rd_r, 32'h0);

    address = 2'd3; in_f = 8'hF0; tick(4);
    chk("fall_capture", rd_f, 32'h0000_000F);
    in_f = 8'hFF; tick(4);
    chk("fall_ignores_rise", rd_f, 32'h0000_000F);
    chk("fall_irq_masked", {31'b0, irq_f}, 32'h0);

    in_a = 8'hFF; tick(4);
    in_a = 8'h00; tick(4);
    chk("any_ecap", rd_a, 32'h0000_00FF);
    chk("any_irq_masked", {31'b0, irq_a}, 32'h0);
    wr(1, 2'd2, 32'h80); tick(1);
    chk("any_irq_unmasked", {31'b0, irq_a}, 32'h1);
    chk("any_irqmask_rd", rd_a, 32'h0000_0080);
    wr(1, 2'd3, 32'h0F); tick(1);
    chk("any_partial_clr", rd_a, 32'h0000_00F0);
    chk("any_partial_irq", {31'b0, irq_a}, 32'h1);
    wr(1, 2'd3, 32'hF0); tick(1);
    chk("any_full_clr", rd_a, 32'h0);
    chk("any_full_clr_irq", {31'b0, irq_a}, 32'h0);

    wr(3, 2'd1, 32'hFFFF_FFFF); tick(1);
    chk("w32_rsvd", rd_w, 32'h0);
    wr(3, 2'd0, 32'hFFFF_FFFF); tick(1);
    chk("w32_data_ro", rd_w, 32'h1234_5678);
    wr(3, 2'd2, 32'hFFFF_FFFF); tick(1);
    chk("w32_irqmask", rd_w, 32'hFFFF_FFFF);
    wr(0, 2'd2, 32'hFFFF_FF03); tick(1);
    chk("w8_irqmask_trunc", rd_r, 32'h0000_0003);
    wr(0, 2'd1, 32'hFFFF_FFFF); tick(1);
    chk("w8_rsvd", rd_r, 32'h0);

    address = 2'd3; in_r = 8'hFF; tick(2);
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(5);
    chk("midreset_ecap", rd_r, 32'h0);
    chk("midreset_irq", {31'b0, irq_r}, 32'h0);
    address = 2'd2; tick(1);
    chk("midreset_irqmask", rd_r, 32'h0);
    address = 2'd0; tick(1);
    chk("midreset_data", rd_r, 32'h0000_00FF);
    in_r = 8'h00; tick(4);
    in_r = 8'h0F; tick(4);
    address = 2'd3; tick(1);
    chk("rearm_capture", rd_r, 32'h0000_000F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
